// File: rtl/tl_scratchpad_responder.sv
// rtl/tl_scratchpad_responder.sv - TileLink-UL scratchpad manager with a one-entry D holding register
module tl_scratchpad_responder #(
  parameter logic [30:0] ADDR_BASE   = 31'h0800_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [4:0]  auto_in_a_bits_source,
  input  logic [30:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [4:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int WB = IW + 3;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_next;
  logic [63:0]     mem [DEPTH_WORDS];
  logic            a_fire, d_fire;
  logic [IW-1:0]   idx;
  logic            hit, is_get, is_put, ok;
  logic            unused_bits;

  // param and the sub-word address bits carry no meaning for a 64-bit word store
  assign unused_bits = ^{auto_in_a_bits_param, auto_in_a_bits_address[2:0]};

  assign idx    = auto_in_a_bits_address[WB-1:3];
  assign hit    = (auto_in_a_bits_address[30:WB] == ADDR_BASE[30:WB]);
  assign is_get = (auto_in_a_bits_opcode == 3'd4);
  assign is_put = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
  assign ok     = hit && (auto_in_a_bits_size <= 3'd3) && (is_get || is_put);

  assign auto_in_a_ready = (state == EMPTY) || auto_in_d_ready;
  assign auto_in_d_valid = (state == FULL);
  // a beat presented during reset must neither load D nor touch memory
  assign a_fire = auto_in_a_valid && auto_in_a_ready && !reset;
  assign d_fire = auto_in_d_valid && auto_in_d_ready;

  assign auto_in_d_bits_param = 2'd0;
  assign auto_in_d_bits_sink  = 1'b0;

  // holding-register occupancy
  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // occupancy next state: a simultaneous A fire keeps the register full
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (a_fire) state_next = FULL;
      FULL:  if (d_fire && !a_fire) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // byte-lane writes for accepted, in-range, uncorrupted Puts
  always_ff @(posedge clock) begin
    if (a_fire && is_put && ok && !auto_in_a_bits_corrupt) begin
      for (int i = 0; i < 8; i++) begin
        if (auto_in_a_bits_mask[i]) mem[idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
      end
    end
  end

  // D holding register: loaded with the response on every accepted A beat
  always_ff @(posedge clock) begin
    if (reset) begin
      auto_in_d_bits_opcode  <= 3'd0;
      auto_in_d_bits_size    <= 3'd0;
      auto_in_d_bits_source  <= 5'd0;
      auto_in_d_bits_denied  <= 1'b0;
      auto_in_d_bits_data    <= 64'd0;
      auto_in_d_bits_corrupt <= 1'b0;
    end else if (a_fire) begin
      auto_in_d_bits_opcode  <= is_get ? 3'd1 : 3'd0;
      auto_in_d_bits_size    <= auto_in_a_bits_size;
      auto_in_d_bits_source  <= auto_in_a_bits_source;
      auto_in_d_bits_denied  <= !ok;
      auto_in_d_bits_data    <= (is_get && ok) ? mem[idx] : 64'd0;
      auto_in_d_bits_corrupt <= is_get && !ok;
    end
  end

endmodule

// File: tb/tb_tl_scratchpad_responder.sv
// tb/tb_tl_scratchpad_responder.sv - scoreboard bench for tl_scratchpad_responder
module tb_tl_scratchpad_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_ready, a_valid;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [4:0]  a_source;
  logic [30:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        d_ready, d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [4:0]  d_source;
  logic        d_sink, d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [4:0]  source;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } resp_t;

  resp_t   exp_q[$];
  int      resp_cycles[$];
  int      checks = 0;
  int      errors = 0;
  int      cycle  = 0;

  tl_scratchpad_responder dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(a_ready), .auto_in_a_valid(a_valid),
    .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
    .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
    .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
    .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
    .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid),
    .auto_in_d_bits_opcode(d_opcode), .auto_in_d_bits_param(d_param),
    .auto_in_d_bits_size(d_size), .auto_in_d_bits_source(d_source),
    .auto_in_d_bits_sink(d_sink), .auto_in_d_bits_denied(d_denied),
    .auto_in_d_bits_data(d_data), .auto_in_d_bits_corrupt(d_corrupt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // monitor: a response handshake completes at the next rising edge
  always @(negedge clock) begin
    if (!reset && d_valid && d_ready) begin
      resp_t e;
      resp_cycles.push_back(cycle);
      if (exp_q.size() == 0) begin
        chk("unexpected_response", {59'd0, d_source}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("d_opcode", {61'd0, d_opcode}, {61'd0, e.opcode});
        chk("d_size",   {61'd0, d_size},   {61'd0, e.size});
        chk("d_source", {59'd0, d_source}, {59'd0, e.source});
        chk("d_denied", {63'd0, d_denied}, {63'd0, e.denied});
        chk("d_param_sink", {61'd0, d_param, d_sink}, 64'd0);
        if (e.opcode == 3'd1) begin
          chk("d_data",    d_data, e.data);
          chk("d_corrupt", {63'd0, d_corrupt}, {63'd0, e.corrupt});
        end
      end
    end
  end

  // drive one A beat until accepted; returns the number of stalled cycles
  task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [4:0] src,
                      input logic [30:0] addr, input logic [7:0] mask, input logic [63:0] data,
                      input logic cor, input resp_t exp, output int stalls);
    logic r;
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_corrupt = cor;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock); r = a_ready;
      @(posedge clock);
      if (r) break;
      stalls++;
    end
    if (stalls >= 20) chk("a_accept_timeout", 64'd0, 64'd1);
    else exp_q.push_back(exp);
    #1 a_valid = 1'b0;
  endtask

  function automatic resp_t mk(input logic [2:0] op, input logic [2:0] sz, input logic [4:0] src,
                               input logic den, input logic cor, input logic [63:0] data);
    resp_t r;
    r.opcode = op; r.size = sz; r.source = src; r.denied = den; r.corrupt = cor; r.data = data;
    return r;
  endfunction

  task automatic drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clock);
    chk("drain_queue_empty", exp_q.size(), 64'd0);
    #1;
  endtask

  initial begin
    int st;
    int base;
    logic [63:0] held;
    reset = 1'b1; a_valid = 1'b0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
    a_address = 0; a_mask = 0; a_data = 0; a_corrupt = 0; d_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_d_valid", {63'd0, d_valid}, 64'd0);
    chk("reset_a_ready", {63'd0, a_ready}, 64'd1);
    chk("reset_d_bits", {d_data[54:0], d_opcode, d_source, d_denied}, 64'd0);
    @(posedge clock); #1;

    // basic write/read and partial write
    send(3'd0, 3'd3, 5'd3, 31'h0800_0010, 8'hFF, 64'h1122334455667788, 1'b0, mk(0, 3, 3, 0, 0, 0), st);
    send(3'd4, 3'd3, 5'd4, 31'h0800_0010, 8'hFF, 64'd0, 1'b0, mk(1, 3, 4, 0, 0, 64'h1122334455667788), st);
    send(3'd1, 3'd3, 5'd5, 31'h0800_0010, 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b0, mk(0, 3, 5, 0, 0, 0), st);
    send(3'd4, 3'd2, 5'd6, 31'h0800_0014, 8'h00, 64'd0, 1'b0, mk(1, 2, 6, 0, 0, 64'h11223344BBBBBBBB), st);
    // out of range, bad opcode, corrupt Put, bad size
    send(3'd4, 3'd3, 5'd7, 31'h0000_0000, 8'hFF, 64'd0, 1'b0, mk(1, 3, 7, 1, 1, 0), st);
    send(3'd2, 3'd3, 5'd8, 31'h0800_0010, 8'hFF, 64'd0, 1'b0, mk(0, 3, 8, 1, 0, 0), st);
    send(3'd0, 3'd3, 5'd9, 31'h0800_0010, 8'hFF, 64'hDEADDEADDEADDEAD, 1'b1, mk(0, 3, 9, 0, 0, 0), st);
    send(3'd0, 3'd4, 5'd10, 31'h0800_0010, 8'hFF, 64'hDEADDEADDEADDEAD, 1'b0, mk(0, 4, 10, 1, 0, 0), st);
    send(3'd4, 3'd4, 5'd11, 31'h0800_0010, 8'hFF, 64'd0, 1'b0, mk(1, 4, 11, 1, 1, 0), st);
    send(3'd4, 3'd3, 5'd12, 31'h0800_0010, 8'hFF, 64'd0, 1'b0, mk(1, 3, 12, 0, 0, 64'h11223344BBBBBBBB), st);
    // window edges: last word hits, first byte past the window misses
    send(3'd0, 3'd3, 5'd13, 31'h0800_1FF8, 8'hFF, 64'h0123456789ABCDEF, 1'b0, mk(0, 3, 13, 0, 0, 0), st);
    send(3'd4, 3'd3, 5'd14, 31'h0800_1FF8, 8'hFF, 64'd0, 1'b0, mk(1, 3, 14, 0, 0, 64'h0123456789ABCDEF), st);
    send(3'd4, 3'd3, 5'd15, 31'h0800_2000, 8'hFF, 64'd0, 1'b0, mk(1, 3, 15, 1, 1, 0), st);
    drain();

    // back-pressure
    d_ready = 1'b0;
    send(3'd4, 3'd3, 5'd16, 31'h0800_0010, 8'hFF, 64'd0, 1'b0, mk(1, 3, 16, 0, 0, 64'h11223344BBBBBBBB), st);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_d_valid", {63'd0, d_valid}, 64'd1);
      chk("bp_a_ready", {63'd0, a_ready}, 64'd0);
      chk("bp_d_data", d_data, 64'h11223344BBBBBBBB);
      chk("bp_d_source", {59'd0, d_source}, 64'd16);
    end
    @(posedge clock); #1;
    d_ready = 1'b1;
    send(3'd4, 3'd3, 5'd17, 31'h0800_1FF8, 8'hFF, 64'd0, 1'b0, mk(1, 3, 17, 0, 0, 64'h0123456789ABCDEF), st);
    chk("bp_release_no_stall", st, 64'd0);
    @(negedge clock);
    chk("bp_next_valid", {63'd0, d_valid}, 64'd1);
    @(posedge clock); #1;
    drain();

    // streaming: 16 Puts then 16 Gets back to back
    base = resp_cycles.size();
    for (int i = 0; i < 16; i++) begin
      send(3'd0, 3'd3, 5'(i), 31'h0800_0100 + 31'(8*i), 8'hFF, {32'hC0DE0000 + 32'(i), 32'(i*3)},
           1'b0, mk(0, 3, 5'(i), 0, 0, 0), st);
      chk("stream_put_no_stall", st, 64'd0);
    end
    for (int i = 0; i < 16; i++) begin
      send(3'd4, 3'd3, 5'(16+i), 31'h0800_0100 + 31'(8*i), 8'hFF, 64'd0, 1'b0,
           mk(1, 3, 5'(16+i), 0, 0, {32'hC0DE0000 + 32'(i), 32'(i*3)}), st);
      chk("stream_get_no_stall", st, 64'd0);
    end
    drain();
    chk("stream_count", resp_cycles.size() - base, 64'd32);
    if (resp_cycles.size() - base == 32)
      chk("stream_span", resp_cycles[base+31] - resp_cycles[base], 64'd31);

    // reset with a response pending; a beat during reset must not write
    d_ready = 1'b0;
    send(3'd4, 3'd3, 5'd20, 31'h0800_0010, 8'hFF, 64'd0, 1'b0, mk(1, 3, 20, 0, 0, 0), st);
    @(negedge clock);
    chk("pre_reset_d_valid", {63'd0, d_valid}, 64'd1);
    @(posedge clock); #1;
    reset = 1'b1; d_ready = 1'b1;
    a_valid = 1'b1; a_opcode = 3'd0; a_size = 3'd3; a_source = 5'd21;
    a_address = 31'h0800_0010; a_mask = 8'hFF; a_data = 64'hBADBADBADBADBAD0;
    @(posedge clock); #1;
    void'(exp_q.pop_front());
    @(posedge clock); #1;
    reset = 1'b0; a_valid = 1'b0;
    @(negedge clock);
    chk("post_reset_d_valid", {63'd0, d_valid}, 64'd0);
    @(posedge clock); #1;
    send(3'd4, 3'd3, 5'd22, 31'h0800_0010, 8'hFF, 64'd0, 1'b0, mk(1, 3, 22, 0, 0, 64'h11223344BBBBBBBB), st);
    send(3'd4, 3'd3, 5'd23, 31'h0800_0178, 8'hFF, 64'd0, 1'b0, mk(1, 3, 23, 0, 0, {32'hC0DE000F, 32'd45}), st);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
